camera_capture: RTL and testbench
=================================

Name: camera_capture

Overview:
- Downstream stage of camera initialisation: once the OV7670 register configuration reports done, this block captures pixel bytes from the sensor's parallel bus.
- Sensor output format is RGB565, two bytes per pixel.
- Each pixel is converted to RGB444 and written into the frame buffer (dual-port BRAM) as address/data/write-enable, one write per pixel.
- Reports frame completion and line-length errors to the recognition logic.

Parameters:
- IMG_W, 640, active pixels per line (href-high width in pixels)
- IMG_H, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  input  1  camera PCLK; all logic on its rising edge
- reset  input  1  asynchronous, active-high
- init_done  input  1  level; high once the SCCB register configuration has finished
- cam_vsync  input  1  sensor VSYNC; high during vertical blanking
- cam_href  input  1  sensor HREF; high during active line bytes
- cam_data  input  8  sensor D[7:0]
- wr_en  output  1  frame-buffer write strobe, one cycle per pixel
- wr_addr  output  ADDR_W  frame-buffer address = line*IMG_W + column
- wr_data  output  12  RGB444 {R[3:0],G[3:0],B[3:0]}
- frame_done  output  1  one-cycle pulse at the end of a captured frame
- frame_cnt  output  8  completed frames, wraps 255->0
- line_err  output  1  sticky; set when any line's pixel count != IMG_W

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; all registers clear immediately on reset.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_cnt=0, line_err=0
  - FSM=IDLE; byte phase=0
- Input registering: cam_vsync, cam_href and cam_data are registered once (stage r). All edge detection and assembly use stage r and its previous value.
- FSM:
  - IDLE: wait for init_done=1, then go to WAIT_VS.
  - WAIT_VS: wait for a vsync_r falling edge (1->0), then go to CAPTURE. This guarantees capture starts on a frame boundary, never mid-frame.
  - CAPTURE: assemble and write pixels while href_r=1. On a vsync_r rising edge:
    - pulse frame_done for one cycle
    - increment frame_cnt
    - go to WAIT_VS
- init_done deassertion in any state returns the FSM to IDLE on the next cycle. No frame_done pulse is generated in that case.
- Byte phase:
  - Cleared whenever href_r=0.
  - Toggles on every href_r=1 cycle in CAPTURE.
  - Phase 0 latches byte0 = {R5, G[5:3]}.
  - Phase 1 combines with byte1 = {G[2:0], B5} to form RGB565.
- Conversion: wr_data = {R5[4:1], G6[5:2], B5[4:1]} (truncation, no rounding).
- Write timing: wr_en is high for exactly the cycle after the phase-1 byte is in stage r. Total latency from the second byte on cam_data to wr_en=1 is 2 clk.
- Addressing:
  - The pixel counter clears on the WAIT_VS->CAPTURE transition.
  - wr_addr carries the counter value of the pixel being written; the counter increments after each write.
  - Once the counter reaches IMG_W*IMG_H, further pixels are dropped: wr_en stays 0, with no wrap and no overwrite of address 0.
- Line check:
  - A per-line pixel counter clears at href_r rising edge.
  - At href_r falling edge in CAPTURE, if count != IMG_W, set line_err.
  - An odd byte count (phase 1 pending when href falls) also sets line_err, and the half-pixel is discarded.
  - line_err clears only on reset.
- Simultaneous events: if vsync_r rises while href_r=1, frame termination wins. The current partial pixel is discarded and line_err is set.
- wr_en is never high outside CAPTURE.

Test Plan:
- Hold init_done=0 and drive a full 4x2 frame (IMG_W=4, IMG_H=2) -> wr_en never asserts, frame_cnt=0.
- Set init_done=1 mid-frame (vsync low, href active) -> no writes until the next vsync fall. The following frame writes addresses 0..7 exactly once each; frame_done pulses once; frame_cnt=1.
- Send pixel bytes 0xF8,0x00 -> wr_data=0xF00. Send 0x07,0xE0 -> 0x0F0. Send 0x00,0x1F -> 0x00F. Each wr_en occurs 2 cycles after the second byte.
- Send a line with 3 pixels (IMG_W=4) -> line_err=1 and stays 1 across subsequent good frames until reset.
- Send 10 pixels in a frame (IMG_W*IMG_H=8) -> exactly 8 writes to addresses 0..7; addresses 8 and 9 are never driven and address 0 is not rewritten.
- Assert reset mid-CAPTURE -> all outputs 0 immediately. After release, with init_done=1, capture restarts only after the next vsync fall, at address 0.

Source files
------------

// File: rtl/camera_capture.sv
// OV7670 pixel capture: assembles RGB565 byte pairs from the sensor bus, truncates
// them to RGB444 and writes one frame-buffer word per pixel, frame-aligned on VSYNC.
//
// state   | meaning
// IDLE    | sensor configuration not finished, nothing captured
// WAIT_VS | armed, waiting for a VSYNC fall so capture starts on a frame boundary
// CAPTURE | assembling pixels and writing them to the frame buffer
module camera_capture #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int LW    = $clog2(IMG_W + 2);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]        state;
  logic              vsync_r, vsync_p;
  logic              href_r, href_p;
  logic [7:0]        data_r;
  logic              phase;
  logic [6:0]        byte0;
  logic [ADDR_W:0]   pix_cnt;
  logic [LW-1:0]     line_cnt;

  logic vs_rise, vs_fall, href_rise, href_fall, pix_full;

  assign vs_rise   = vsync_r & ~vsync_p;
  assign vs_fall   = ~vsync_r & vsync_p;
  assign href_rise = href_r & ~href_p;
  assign href_fall = ~href_r & href_p;
  assign pix_full  = (pix_cnt >= TOTAL[ADDR_W:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vsync_r    <= 1'b0;
      vsync_p    <= 1'b0;
      href_r     <= 1'b0;
      href_p     <= 1'b0;
      data_r     <= '0;
      phase      <= 1'b0;
      byte0      <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      vsync_r    <= cam_vsync;
      vsync_p    <= vsync_r;
      href_r     <= cam_href;
      href_p     <= href_r;
      data_r     <= cam_data;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      if (!href_r)
        phase <= 1'b0;
      if (href_rise)
        line_cnt <= '0;

      if (!init_done) begin
        state <= IDLE;
        phase <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_VS;

          WAIT_VS: begin
            if (vs_fall) begin
              state   <= CAPTURE;
              pix_cnt <= '0;
            end
          end

          CAPTURE: begin
            if (vs_rise) begin
              // frame end beats any half-assembled pixel; a live line is flagged as short
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              state      <= WAIT_VS;
              phase      <= 1'b0;
              if (href_r)
                line_err <= 1'b1;
            end else begin
              if (href_fall && ((line_cnt != IMG_W[LW-1:0]) || phase))
                line_err <= 1'b1;
              if (href_r) begin
                phase <= ~phase;
                if (!phase) begin
                  byte0 <= {data_r[7:4], data_r[2:0]};
                end else begin
                  if (line_cnt != '1)
                    line_cnt <= line_cnt + 1'b1;
                  if (!pix_full) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_cnt[ADDR_W-1:0];
                    wr_data <= {byte0[6:3], byte0[2:0], data_r[7], data_r[4:1]};
                    pix_cnt <= pix_cnt + 1'b1;
                  end
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a 4x2 frame; expected writes are queued as
// pixels are driven and matched (address, data, latency) when wr_en appears.
module tb_camera_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_done = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          line_err;

  camera_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   data;
    int            cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         e_m;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          fd_count = 0;
  int          exp_addr = 0;
  int          dir_idx = 3;
  int          hits[8];
  logic [11:0] got[8];
  logic [7:0]  dir_b0[3] = '{8'hF8, 8'h07, 8'h00};
  logic [7:0]  dir_b1[3] = '{8'h00, 8'hE0, 8'h1F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [7:0] b0, input logic [7:0] b1);
    logic [4:0] r, b;
    logic [5:0] g;
    r = b0[7:3];
    g = {b0[2:0], b1[7:5]};
    b = b1[4:0];
    return {r[4:1], g[5:2], b[4:1]};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (wr_en) begin
      wr_count++;
      chk("write_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_m = sb.pop_front();
        chk("wr_addr", wr_addr, e_m.addr);
        chk("wr_data", wr_data, e_m.data);
        chk("wr_latency", cyc, e_m.cyc);
      end
      hits[wr_addr]++;
      got[wr_addr] = wr_data;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_pixel(input bit exp_on);
    logic [7:0] b0, b1;
    wr_t t;
    if (dir_idx < 3) begin
      b0 = dir_b0[dir_idx];
      b1 = dir_b1[dir_idx];
      dir_idx++;
    end else begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
    end
    cam_href = 1'b1;
    cam_data = b0;
    tick();
    cam_data = b1;
    if (exp_on && exp_addr < W * H) begin
      t.addr = exp_addr[AW-1:0];
      t.data = model(b0, b1);
      t.cyc  = cyc + 2;
      sb.push_back(t);
    end
    if (exp_on) exp_addr++;
    tick();
  endtask

  task automatic send_line(input int n, input bit exp_on);
    for (int i = 0; i < n; i++) send_pixel(exp_on);
    cam_href = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic clear_stats();
    wr_count = 0;
    fd_count = 0;
    exp_addr = 0;
    for (int i = 0; i < 8; i++) hits[i] = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_err", line_err, 0);
  endtask

  task automatic chk_hits_once(input string tag);
    for (int i = 0; i < 8; i++) chk(tag, hits[i], 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    repeat (2) tick();
    chk_reset_outputs();
    reset = 1'b0;
    tick();

    // no configuration yet: a full frame must be ignored
    frame_start();
    send_line(W, 0);
    send_line(W, 0);
    frame_end();
    chk("noinit_writes", wr_count, 0);
    chk("noinit_frame_cnt", frame_cnt, 0);
    chk("noinit_frame_done", fd_count, 0);

    // configuration finishes mid-line: rest of this frame is skipped
    clear_stats();
    frame_start();
    send_pixel(0);
    send_pixel(0);
    init_done = 1'b1;
    send_pixel(0);
    send_pixel(0);
    cam_href = 1'b0;
    repeat (3) tick();
    send_line(W, 0);
    frame_end();
    chk("midframe_writes", wr_count, 0);
    chk("midframe_frame_done", fd_count, 0);
    chk("midframe_frame_cnt", frame_cnt, 0);

    clear_stats();
    dir_idx = 0;
    frame_start();
    send_line(W, 1);
    send_line(W, 1);
    frame_end();
    chk("f1_writes", wr_count, 8);
    chk("f1_frame_done", fd_count, 1);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_line_err", line_err, 0);
    chk_hits_once("f1_addr_once");
    chk("red_pixel", got[0], 12'hF00);
    chk("green_pixel", got[1], 12'h0F0);
    chk("blue_pixel", got[2], 12'h00F);

    // short line sets the sticky error
    clear_stats();
    frame_start();
    send_line(3, 1);
    send_line(W, 1);
    frame_end();
    chk("short_line_err", line_err, 1);
    chk("short_writes", wr_count, 7);
    chk("short_frame_cnt", frame_cnt, 2);

    clear_stats();
    frame_start();
    send_line(W, 1);
    send_line(W, 1);
    frame_end();
    chk("sticky_line_err", line_err, 1);
    chk("good_writes", wr_count, 8);
    chk("good_frame_cnt", frame_cnt, 3);

    // ten pixels into an eight-pixel buffer
    clear_stats();
    frame_start();
    send_line(W, 1);
    send_line(W, 1);
    send_line(2, 1);
    frame_end();
    chk("ovf_writes", wr_count, 8);
    chk_hits_once("ovf_addr_once");
    chk("ovf_frame_cnt", frame_cnt, 4);
    chk("ovf_frame_done", fd_count, 1);

    // reset in the middle of a captured line
    clear_stats();
    frame_start();
    send_pixel(1);
    send_pixel(1);
    cam_href = 1'b1;
    cam_data = 8'h55;
    tick();
    chk("pre_reset_wr_en", wr_en, 1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs();
    chk("pre_reset_drained", sb.size(), 0);
    tick();
    reset = 1'b0;
    clear_stats();
    send_pixel(0);
    cam_href = 1'b0;
    repeat (3) tick();
    send_line(W, 0);
    frame_end();
    chk("post_reset_idle_writes", wr_count, 0);
    chk("post_reset_idle_frame_done", fd_count, 0);

    clear_stats();
    frame_start();
    send_line(W, 1);
    send_line(W, 1);
    frame_end();
    chk("restart_writes", wr_count, 8);
    chk_hits_once("restart_addr_once");
    chk("restart_frame_cnt", frame_cnt, 1);
    chk("restart_frame_done", fd_count, 1);
    chk("restart_line_err", line_err, 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
